// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types for the bit-serial adder.
// Holds the state bundle and its reset value.
package serial_adder_pkg;

  localparam logic RESET_VAL = 1'b0;

  typedef struct packed {
    logic carry;
    logic sum;
  } sa_state_t;

  localparam sa_state_t RESET_STATE = '{
    carry: RESET_VAL,
    sum:   RESET_VAL
  };

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand bits in (a, b, c_in),
// registered result bits out (s_out, c_out).
interface serial_adder_if;

  logic a;
  logic b;
  logic c_in;
  logic c_out;
  logic s_out;

  modport master (
    output a,
    output b,
    output c_in,
    input  c_out,
    input  s_out
  );

  modport slave (
    input  a,
    input  b,
    input  c_in,
    output c_out,
    output s_out
  );

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: combinational one-bit full adder.
// Ports: a, b, ci in; s (sum), co (carry) out.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one carry flop.
// Ports: clk, rst (async, active-low), bus (slave: a/b/c_in in, s_out/c_out out).
module serial_adder
  import serial_adder_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  sa_state_t st_q;
  sa_state_t st_d;
  logic      cin_eff;

  // c_in is ORed in, so it never adds on top of a live carry.
  assign cin_eff = st_q.carry | bus.c_in;

  full_adder_cell u_fa (
    .a  (bus.a),
    .b  (bus.b),
    .ci (cin_eff),
    .s  (st_d.sum),
    .co (st_d.carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= RESET_STATE;
    end else begin
      st_q <= st_d;
    end
  end

  assign bus.c_out = st_q.carry;
  assign bus.s_out = st_q.sum;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random words checked
// against integer addition of the framed operands.
module tb_serial_adder;

  logic clk;
  logic rst;

  serial_adder_if bus ();

  serial_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic  obs,
    input logic  exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  // Reset with random junk on the inputs; async clear
  // is checked before any clock edge arrives.
  task automatic do_reset();
    @(negedge clk);
    #2;
    bus.a    = 1'($urandom);
    bus.b    = 1'($urandom);
    bus.c_in = 1'($urandom);
    rst      = 1'b0;
    #1;
    check("rst_async_s", bus.s_out, 1'b0);
    check("rst_async_c", bus.c_out, 1'b0);
    repeat (2) begin
      @(posedge clk);
      bus.a    = 1'($urandom);
      bus.b    = 1'($urandom);
      bus.c_in = 1'($urandom);
      #1;
      check("rst_hold_s", bus.s_out, 1'b0);
      check("rst_hold_c", bus.c_out, 1'b0);
    end
    @(negedge clk);
    bus.a    = 1'b0;
    bus.b    = 1'b0;
    bus.c_in = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // Feeds n bits of A and B LSB first, c_in on bit 0 only.
  // After edge k, s_out must be bit k of A+B+ci (over bits
  // 0..k) and c_out the carry into bit k+1.
  task automatic run_word(
    input string       tag,
    input logic [31:0] op_a,
    input logic [31:0] op_b,
    input int          n,
    input logic        ci
  );
    logic [33:0] mask;
    logic [33:0] part;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.a    = op_a[k];
      bus.b    = op_b[k];
      bus.c_in = (k == 0) ? ci : 1'b0;
      mask = (34'd1 << (k + 1)) - 34'd1;
      part = ({2'b00, op_a} & mask)
           + ({2'b00, op_b} & mask)
           + {33'd0, ci};
      @(posedge clk);
      #1;
      check({tag, "_s"}, bus.s_out, part[k]);
      check({tag, "_c"}, bus.c_out, part[k + 1]);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          rn;

    rst      = 1'b1;
    bus.a    = 1'b0;
    bus.b    = 1'b0;
    bus.c_in = 1'b0;

    do_reset();

    run_word("d13p9", 32'd13, 32'd9, 4, 1'b0);
    do_reset();
    run_word("d8p1", 32'd8, 32'd1, 4, 1'b0);
    do_reset();
    run_word("d11p9ci", 32'd11, 32'd9, 4, 1'b1);
    do_reset();
    run_word("ripple", 32'd15, 32'd1, 4, 1'b0);
    do_reset();

    // Abort a carry-generating word after two bits.
    run_word("mid", 32'd15, 32'd15, 2, 1'b0);
    do_reset();
    run_word("after_mid", 32'd1, 32'd1, 4, 1'b0);
    do_reset();

    // c_in over a live carry contributes only 1.
    @(negedge clk);
    bus.a = 1'b1; bus.b = 1'b1; bus.c_in = 1'b0;
    @(posedge clk); #1;
    check("or_b0_s", bus.s_out, 1'b0);
    check("or_b0_c", bus.c_out, 1'b1);
    @(negedge clk);
    bus.a = 1'b1; bus.b = 1'b0; bus.c_in = 1'b1;
    @(posedge clk); #1;
    check("or_b1_s", bus.s_out, 1'b0);
    check("or_b1_c", bus.c_out, 1'b1);
    do_reset();

    // Idle zeros keep outputs at zero.
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_s", bus.s_out, 1'b0);
      check("idle_c", bus.c_out, 1'b0);
    end

    for (int w = 0; w < 25; w++) begin
      rn = $urandom_range(1, 31);
      ra = $urandom & ((32'd1 << rn) - 32'd1);
      rb = $urandom & ((32'd1 << rn) - 32'd1);
      run_word("rnd", ra, rb, rn, 1'($urandom));
      do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
